// File: rtl/frost32_mem_responder_pkg.sv
// Shared CPU package for the Frost32 memory responder.
// Holds the data-port access type/size enums used by the CPU, the
// responder state enum and the latency counter width.
package frost32_mem_responder_pkg;

  // Direction of a data-port access.
  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;

  // Width of a data-port access; encoding 2'd3 is reserved and faults.
  typedef enum logic [1:0] {
    Dias8  = 2'd0,
    Dias16 = 2'd1,
    Dias32 = 2'd2
  } DataInoutAccessSize;

  // Responder handshake states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } MemResponderState;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int unsigned RESPONDER_COUNTER_WIDTH = 4;

endpackage

// File: rtl/frost32_mem_responder_mem_array.sv
// Frost32MemArray: synchronous single-port word RAM with byte enables.
// Ports:
//   clk        clock
//   i_addr     word index (read and write share the port)
//   i_we       write strobe
//   i_byte_en  per-byte write enables, bit n covers bits [8n+7:8n]
//   i_wr_data  write data, already replicated onto the addressed lanes
//   o_rd_data  registered read data (old contents on a same-cycle write)
// Contents are never reset.
module Frost32MemArray #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_we,
  input  logic [3:0]        i_byte_en,
  input  logic [31:0]       i_wr_data,
  output logic [31:0]       o_rd_data
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_byte_en[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wr_data[8*i +: 8];
        end
      end
    end
    r_rd_data <= r_mem[i_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/frost32_mem_responder.sv
// frost32_mem_responder: fixed-latency memory responder for the Frost32
// data port. Accepts one access in StIdle, counts LATENCY cycles in StBusy,
// then presents the result for one cycle in StDone.
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_req_mem_access                access request (held until wait falls)
//   in_addr                          byte address
//   in_data                          right-justified write data
//   in_data_inout_access_type        0 read, 1 write
//   in_data_inout_access_size        0 byte, 1 half, 2 word, 3 reserved
//   out_data                         right-justified zero-extended read data
//   out_wait_for_mem                 high while an accepted access is pending
//   out_mem_error                    high in the response cycle of a fault
module frost32_mem_responder
  import frost32_mem_responder_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int LATENCY         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_req_mem_access,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic        in_data_inout_access_type,
  input  logic [1:0]  in_data_inout_access_size,
  output logic [31:0] out_data,
  output logic        out_wait_for_mem,
  output logic        out_mem_error
);

  localparam int ADDR_W = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_WORDS = 32'(MEM_DEPTH_WORDS);
  localparam logic [RESPONDER_COUNTER_WIDTH-1:0] COUNT_LOAD =
    RESPONDER_COUNTER_WIDTH'(LATENCY - 1);

  MemResponderState                   r_state;
  logic [RESPONDER_COUNTER_WIDTH-1:0] r_counter;
  logic [31:0]                        r_addr;
  logic [31:0]                        r_data;
  DataInoutAccessType                 r_type;
  logic [1:0]                         r_size;

  logic              w_misaligned;
  logic              w_out_of_range;
  logic              w_fault;
  logic              w_last_cycle;
  logic              w_ram_we;
  logic [3:0]        w_byte_en;
  logic [31:0]       w_wr_data;
  logic [31:0]       w_rd_data;
  logic [31:0]       w_rd_lane;
  logic [ADDR_W-1:0] w_ram_addr;

  // Lane steering and alignment, all from the latched request.
  always_comb begin
    w_byte_en    = 4'b0000;
    w_wr_data    = r_data;
    w_rd_lane    = w_rd_data;
    w_misaligned = 1'b0;
    case (r_size)
      Dias8: begin
        w_byte_en = 4'b0001 << r_addr[1:0];
        w_wr_data = {4{r_data[7:0]}};
        w_rd_lane = {24'h0, w_rd_data[{r_addr[1:0], 3'b000} +: 8]};
      end
      Dias16: begin
        w_byte_en    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wr_data    = {2{r_data[15:0]}};
        w_rd_lane    = {16'h0, (r_addr[1] ? w_rd_data[31:16] : w_rd_data[15:0])};
        w_misaligned = r_addr[0];
      end
      Dias32: begin
        w_byte_en    = 4'b1111;
        w_misaligned = |r_addr[1:0];
      end
      default: begin
        w_misaligned = 1'b1;  // reserved size
      end
    endcase
  end

  assign w_out_of_range = {2'b00, r_addr[31:2]} >= DEPTH_WORDS;
  assign w_fault        = w_misaligned | w_out_of_range;
  assign w_last_cycle   = (r_state == StBusy) && (r_counter == '0);
  assign w_ram_we       = w_last_cycle && (r_type == DiatWrite) && !w_fault;

  // The RAM read is registered, so while idle it is pointed at the incoming
  // address; the word is then ready at the response edge even for LATENCY=1.
  // Afterwards the latched address keeps it stable.
  assign w_ram_addr = (r_state == StIdle) ? in_addr[ADDR_W+1:2] : r_addr[ADDR_W+1:2];

  Frost32MemArray #(
    .DEPTH_WORDS (MEM_DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_mem_array (
    .clk       (clk),
    .i_addr    (w_ram_addr),
    .i_we      (w_ram_we),
    .i_byte_en (w_byte_en),
    .i_wr_data (w_wr_data),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= StIdle;
      r_counter        <= '0;
      r_addr           <= '0;
      r_data           <= '0;
      r_type           <= DiatRead;
      r_size           <= 2'b00;
      out_data         <= '0;
      out_wait_for_mem <= 1'b0;
      out_mem_error    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_req_mem_access) begin
            r_addr           <= in_addr;
            r_data           <= in_data;
            r_type           <= DataInoutAccessType'(in_data_inout_access_type);
            r_size           <= in_data_inout_access_size;
            r_counter        <= COUNT_LOAD;
            out_wait_for_mem <= 1'b1;
            r_state          <= StBusy;
          end
        end
        StBusy: begin
          if (r_counter != '0) begin
            r_counter <= r_counter - RESPONDER_COUNTER_WIDTH'(1);
          end else begin
            // Write responses and faults return zero data.
            out_data         <= (w_fault || (r_type == DiatWrite)) ? 32'h0 : w_rd_lane;
            out_mem_error    <= w_fault;
            out_wait_for_mem <= 1'b0;
            r_state          <= StDone;
          end
        end
        StDone: begin
          out_mem_error <= 1'b0;
          r_state       <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frost32_mem_responder.sv
module tb_frost32_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        req  = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        typ  = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] out_data;
  logic        out_wait;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          chk_data;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cycles;
    logic        err_after;
    logic [31:0] data_after;
  } obs_t;

  typedef struct {
    logic        t;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] ed;
    logic        ee;
    bit          cd;
  } op_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  logic [31:0] model [8];

  always #5 clk = ~clk;

  frost32_mem_responder #(
    .MEM_DEPTH_WORDS (DEPTH),
    .LATENCY         (LAT)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .in_req_mem_access         (req),
    .in_addr                   (addr),
    .in_data                   (wdata),
    .in_data_inout_access_type (typ),
    .in_data_inout_access_size (size),
    .out_data                  (out_data),
    .out_wait_for_mem          (out_wait),
    .out_mem_error             (out_err)
  );

  // Drives one access, scrambles the request fields while busy, and pushes
  // what the DUT produced onto the observation queue.
  task automatic do_access(input logic t, input logic [1:0] s,
                           input logic [31:0] a, input logic [31:0] d);
    obs_t o;
    @(negedge clk);
    req = 1'b1; typ = t; size = s; addr = a; wdata = d;
    @(posedge clk); #1;
    addr = ~a; wdata = ~d; typ = ~t; size = ~s;
    o.cycles = 0;
    while (out_wait === 1'b1 && o.cycles < 40) begin
      @(posedge clk); #1;
      o.cycles++;
    end
    o.data = out_data;
    o.err  = out_err;
    req = 1'b0;
    @(posedge clk); #1;
    o.err_after  = out_err;
    o.data_after = out_data;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    req = 1'b1; addr = 32'h10; typ = 1'b0; size = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got %0b expected 0", out_wait); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %08h expected 00000000", out_data); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b expected 0", out_err); end
    $display("reset: wait=%0b data=%08h err=%0b", out_wait, out_data, out_err);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word_rw();
    exp_t e; obs_t o;
    e = '{data: 32'h0, err: 1'b0, chk_data: 1'b0};
    exp_q.push_back(e);
    do_access(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
    e = '{data: 32'hDEADBEEF, err: 1'b0, chk_data: 1'b1};
    exp_q.push_back(e);
    do_access(1'b0, 2'd2, 32'h10, 32'h0);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.cycles != LAT) begin errors++; $display("FAIL word_latency[%0d] got %0d expected %0d", i, o.cycles, LAT); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL word_err[%0d] got %0b expected %0b", i, o.err, e.err); end
      if (e.chk_data) begin
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL word_data[%0d] got %08h expected %08h", i, o.data, e.data); end
      end
      $display("word[%0d]: data=%08h err=%0b wait_cycles=%0d", i, o.data, o.err, o.cycles);
    end
  endtask

  task automatic test_lanes();
    op_t ops[7]; exp_t e; obs_t o;
    ops[0] = '{1'b1, 2'd0, 32'h12, 32'hABCDEF11, 32'h0,        1'b0, 1'b0};
    ops[1] = '{1'b0, 2'd2, 32'h10, 32'h0,        32'hDE11BEEF, 1'b0, 1'b1};
    ops[2] = '{1'b0, 2'd1, 32'h12, 32'h0,        32'h0000DE11, 1'b0, 1'b1};
    ops[3] = '{1'b0, 2'd0, 32'h13, 32'h0,        32'h000000DE, 1'b0, 1'b1};
    ops[4] = '{1'b0, 2'd0, 32'h10, 32'h0,        32'h000000EF, 1'b0, 1'b1};
    ops[5] = '{1'b1, 2'd1, 32'h10, 32'h1234CAFE, 32'h0,        1'b0, 1'b0};
    ops[6] = '{1'b0, 2'd2, 32'h10, 32'h0,        32'hDE11CAFE, 1'b0, 1'b1};
    foreach (ops[i]) begin
      e = '{data: ops[i].ed, err: ops[i].ee, chk_data: ops[i].cd};
      exp_q.push_back(e);
      do_access(ops[i].t, ops[i].s, ops[i].a, ops[i].d);
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.cycles != LAT) begin errors++; $display("FAIL lanes_latency[%0d] got %0d expected %0d", i, o.cycles, LAT); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL lanes_err[%0d] got %0b expected %0b", i, o.err, e.err); end
      if (e.chk_data) begin
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL lanes_data[%0d] got %08h expected %08h", i, o.data, e.data); end
      end
      $display("lanes[%0d]: t=%0b s=%0d a=%08h data=%08h err=%0b", i, ops[i].t, ops[i].s, ops[i].a, o.data, o.err);
    end
  endtask

  task automatic test_faults();
    op_t ops[13]; exp_t e; obs_t o;
    ops[0]  = '{1'b0, 2'd2, 32'h11,             32'h0,        32'h0,        1'b1, 1'b1};
    ops[1]  = '{1'b1, 2'd1, 32'h13,             32'h00007777, 32'h0,        1'b1, 1'b1};
    ops[2]  = '{1'b0, 2'd2, 32'h10,             32'h0,        32'hDE11CAFE, 1'b0, 1'b1};
    ops[3]  = '{1'b1, 2'd2, 32'h12,             32'h99999999, 32'h0,        1'b1, 1'b1};
    ops[4]  = '{1'b0, 2'd2, 32'h10,             32'h0,        32'hDE11CAFE, 1'b0, 1'b1};
    ops[5]  = '{1'b1, 2'd2, 32'h0,              32'h0BADF00D, 32'h0,        1'b0, 1'b0};
    ops[6]  = '{1'b1, 2'd2, 32'(4*DEPTH),       32'h66666666, 32'h0,        1'b1, 1'b1};
    ops[7]  = '{1'b0, 2'd2, 32'(4*DEPTH),       32'h0,        32'h0,        1'b1, 1'b1};
    ops[8]  = '{1'b0, 2'd3, 32'h0,              32'h0,        32'h0,        1'b1, 1'b1};
    ops[9]  = '{1'b0, 2'd2, 32'h0,              32'h0,        32'h0BADF00D, 1'b0, 1'b1};
    ops[10] = '{1'b1, 2'd2, 32'(4*(DEPTH-1)),   32'h01234567, 32'h0,        1'b0, 1'b0};
    ops[11] = '{1'b0, 2'd2, 32'(4*(DEPTH-1)),   32'h0,        32'h01234567, 1'b0, 1'b1};
    ops[12] = '{1'b0, 2'd2, 32'hFFFFFFFC,       32'h0,        32'h0,        1'b1, 1'b1};
    foreach (ops[i]) begin
      e = '{data: ops[i].ed, err: ops[i].ee, chk_data: ops[i].cd};
      exp_q.push_back(e);
      do_access(ops[i].t, ops[i].s, ops[i].a, ops[i].d);
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.cycles != LAT) begin errors++; $display("FAIL fault_latency[%0d] got %0d expected %0d", i, o.cycles, LAT); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL fault_err[%0d] got %0b expected %0b", i, o.err, e.err); end
      checks++; if (o.err_after !== 1'b0) begin errors++; $display("FAIL fault_err_clear[%0d] got %0b expected 0", i, o.err_after); end
      if (e.chk_data) begin
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL fault_data[%0d] got %08h expected %08h", i, o.data, e.data); end
        checks++; if (o.data_after !== e.data) begin errors++; $display("FAIL fault_data_hold[%0d] got %08h expected %08h", i, o.data_after, e.data); end
      end
      $display("fault[%0d]: t=%0b s=%0d a=%08h data=%08h err=%0b", i, ops[i].t, ops[i].s, ops[i].a, o.data, o.err);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; obs_t o;
    do_access(1'b1, 2'd2, 32'h20, 32'h12345678);
    void'(obs_q.pop_front());
    do_access(1'b0, 2'd2, 32'h20, 32'h0);
    o = obs_q.pop_front();
    checks++; if (o.data !== 32'h12345678) begin errors++; $display("FAIL rstmid_pre got %08h expected 12345678", o.data); end
    @(negedge clk);
    req = 1'b1; typ = 1'b1; size = 2'd2; addr = 32'h20; wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    checks++; if (out_wait !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %0b expected 1", out_wait); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_wait !== 1'b0 || out_data !== 32'h0 || out_err !== 1'b0)
      begin errors++; $display("FAIL rstmid_outputs got wait=%0b data=%08h err=%0b expected 0/00000000/0", out_wait, out_data, out_err); end
    req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    e = '{data: 32'h12345678, err: 1'b0, chk_data: 1'b1};
    exp_q.push_back(e);
    do_access(1'b0, 2'd2, 32'h20, 32'h0);
    e = exp_q.pop_front(); o = obs_q.pop_front();
    checks++; if (o.cycles != LAT) begin errors++; $display("FAIL rstmid_latency got %0d expected %0d", o.cycles, LAT); end
    checks++; if (o.data !== e.data) begin errors++; $display("FAIL rstmid_preserved got %08h expected %08h", o.data, e.data); end
    $display("rstmid: read 0x20 after aborted write data=%08h", o.data);
  endtask

  task automatic test_held();
    exp_t e;
    logic prev_wait;
    int   accepts;
    int   last_acc;
    @(negedge clk);
    req = 1'b1; typ = 1'b0; size = 2'd2; addr = 32'h10; wdata = 32'h0;
    prev_wait = 1'b0; accepts = 0; last_acc = 0;
    for (int k = 0; k < 4*(LAT+2); k++) begin
      @(posedge clk); #1;
      if (!prev_wait && out_wait) begin
        if (accepts > 0) begin
          checks++; if (k - last_acc != LAT + 2) begin errors++; $display("FAIL held_spacing got %0d expected %0d", k - last_acc, LAT + 2); end
        end
        accepts++; last_acc = k;
        e = '{data: 32'hDE11CAFE, err: 1'b0, chk_data: 1'b1};
        exp_q.push_back(e);
      end
      if (prev_wait && !out_wait) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL held_unexpected_response got 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          checks++; if (out_data !== e.data || out_err !== e.err)
            begin errors++; $display("FAIL held_response got %08h/%0b expected %08h/%0b", out_data, out_err, e.data, e.err); end
          $display("held: response at cycle %0d data=%08h err=%0b", k, out_data, out_err);
        end
      end
      prev_wait = out_wait;
    end
    req = 1'b0;
    checks++; if (accepts != 4) begin errors++; $display("FAIL held_accepts got %0d expected 4", accepts); end
    exp_q.delete();
    repeat (LAT + 2) @(posedge clk);
  endtask

  task automatic test_random();
    exp_t e; obs_t o;
    logic        t, fault;
    logic [1:0]  s;
    logic [31:0] a, d, w;
    int          idx;
    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      do_access(1'b1, 2'd2, 32'h100 + 32'(4*i), model[i]);
      void'(obs_q.pop_front());
    end
    for (int i = 0; i < 24; i++) begin
      t = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = 32'h100 + 32'($urandom_range(0, 31));
      d = $urandom;
      idx = int'((a - 32'h100) >> 2);
      w = model[idx];
      fault = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
      e = '{data: 32'h0, err: fault, chk_data: 1'b1};
      if (!fault && t) begin
        e.chk_data = 1'b0;
        case (s)
          2'd0:    w[{a[1:0], 3'b000} +: 8]  = d[7:0];
          2'd1:    w[{a[1], 4'b0000} +: 16]  = d[15:0];
          default: w = d;
        endcase
        model[idx] = w;
      end else if (!fault) begin
        case (s)
          2'd0:    e.data = {24'h0, w[{a[1:0], 3'b000} +: 8]};
          2'd1:    e.data = {16'h0, w[{a[1], 4'b0000} +: 16]};
          default: e.data = w;
        endcase
      end
      exp_q.push_back(e);
      do_access(t, s, a, d);
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.cycles != LAT) begin errors++; $display("FAIL rand_latency[%0d] got %0d expected %0d", i, o.cycles, LAT); end
      checks++; if (o.err !== e.err) begin errors++; $display("FAIL rand_err[%0d] got %0b expected %0b", i, o.err, e.err); end
      if (e.chk_data) begin
        checks++; if (o.data !== e.data) begin errors++; $display("FAIL rand_data[%0d] got %08h expected %08h", i, o.data, e.data); end
      end
      $display("rand[%0d]: t=%0b s=%0d a=%08h d=%08h data=%08h err=%0b", i, t, s, a, d, o.data, o.err);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_lanes();
    test_faults();
    test_reset_mid();
    test_held();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/frost32_mem_responder.md
FROST32_MEM_RESPONDER -- requirements
Module: frost32_mem_responder

Interface
REQ-001 Parameter MEM_DEPTH_WORDS, default 1024: number of 32-bit words in the backing store.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to response; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_req_mem_access  input  1  initiator requests an access; held high until wait_for_mem falls.
REQ-006 in_addr  input  32  byte address of the access.
REQ-007 in_data  input  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
REQ-008 in_data_inout_access_type  input  1  DiatRead=0, DiatWrite=1.
REQ-009 in_data_inout_access_size  input  2  Dias8=0, Dias16=1, Dias32=2, 3 reserved.
REQ-010 out_data  output  32  read data, right-justified, zero-extended.
REQ-011 out_wait_for_mem  output  1  high while an accepted access is in progress.
REQ-012 out_mem_error  output  1  high during the response cycle of a faulting access.

Function
REQ-013 The FSM shall have the states StIdle, StBusy and StDone.
REQ-014 In StIdle, when in_req_mem_access=1 at posedge: latch addr, data, type and size; load counter with LATENCY-1; set wait_for_mem=1; go to StBusy.
REQ-015 In StBusy with counter!=0: decrement the counter; all outputs hold.
REQ-016 In StBusy with counter==0: perform the access; set wait_for_mem=0; go to StDone.
REQ-017 In StDone: out_data and out_mem_error are valid for this one cycle; in_req_mem_access is ignored; go to StIdle next edge.
REQ-018 Response latency: out_data is valid exactly LATENCY cycles after the accepting edge; back-to-back accesses are accepted at most every LATENCY+2 cycles.
REQ-019 Byte order is little-endian: the byte at addr[1:0]=n occupies word bits [8n+7:8n].
REQ-020 Word index = addr[31:2].
REQ-021 Dias8 reads return {24'h0, selected byte}; Dias16 reads select the halfword by addr[1] and return {16'h0, halfword}.
REQ-022 Writes shall modify only the addressed lanes; all other bytes are preserved.
REQ-023 Fault conditions:
- Dias16 with addr[0]=1
- Dias32 with addr[1:0]!=0
- size=3
- word index >= MEM_DEPTH_WORDS
REQ-024 On a fault: out_mem_error=1 in StDone; out_data=0; no write occurs.
REQ-025 Outside StDone, out_data holds its last value and out_mem_error=0.
REQ-026 Latched request fields shall not change while in StBusy, regardless of input activity.

Reset
REQ-027 Asserting rst at any time shall force StIdle, counter=0, out_wait_for_mem=0, out_data=0, out_mem_error=0.
REQ-028 Reset during StBusy aborts the access: a pending write shall not modify storage.
REQ-029 Storage contents are not reset; they are preserved across rst.
REQ-030 The first acceptance after deassertion shall occur on the first posedge with rst=0 and in_req_mem_access=1.

Structure
REQ-031 The access type/size enums (DiatRead/DiatWrite, Dias8/16/32) shall reside in the shared CPU package and be reused unchanged.
REQ-032 The shared package shall add the responder state enum (StIdle/StBusy/StDone) and the counter width constant.
REQ-033 Storage shall be one sub-module, Frost32MemArray: a synchronous word RAM with 4-bit byte enables and one read/write port.
REQ-034 Lane selection, alignment checks and fault logic shall reside in frost32_mem_responder.

Verification
REQ-035 Word write then read, LATENCY=2: write addr 0x10 data 0xDEADBEEF; read 0x10 -> out_data=0xDEADBEEF two cycles after the accepting edge, wait_for_mem high for exactly 2 cycles.
REQ-036 Byte/half lanes: after REQ-035, Dias8 write 0x11 to 0x12, then Dias32 read 0x10 -> 0xDE11BEEF; Dias16 read 0x12 -> 0x0000DE11; Dias8 read 0x13 -> 0x000000DE.
REQ-037 Misalignment: Dias32 read 0x11 -> out_mem_error=1, out_data=0; Dias16 write 0x13 -> error=1 and a following word read of 0x10 is unchanged.
REQ-038 Range: Dias32 read of 4*MEM_DEPTH_WORDS -> out_mem_error=1; size=3 at 0x0 -> out_mem_error=1.
REQ-039 Reset mid-access: start write 0x55AA55AA to 0x20, assert rst in StBusy -> outputs zero immediately; a subsequent read of 0x20 returns the prior contents.
REQ-040 Held request: in_req_mem_access kept high continuously -> exactly one access per LATENCY+2 cycles, with no duplicate acceptance in StDone.
